// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped UART transmitter with a TX FIFO, serialising 8N1 on o_tx.
// Define UART_TX_PARITY_EN to build the optional even-parity (8E1) frame mode on STATUS[5].
module io_uart_tx #(
    parameter logic [1:0]  XLEN             = 2'b10,
    parameter int          FIFO_DEPTH       = 8,
    parameter logic [15:0] DEFAULT_BAUD_DIV = 16'd867,
    localparam int         W                = 1 << (XLEN + 4)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clk_en,
    input  logic         i_io_en_m,
    input  logic         i_sw_m,
    input  logic         i_lw_m,
    input  logic [W-1:0] i_addr_m,
    input  logic [W-1:0] i_wdata_m,
    output logic [W-1:0] o_rdata_m,
    output logic         o_tx,
    output logic         o_irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP
`ifdef UART_TX_PARITY_EN
        , PARITY
`endif
    } state_t;
    state_t        state_q, state_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   baud_q, div_q, div_d, cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_q, bit_d;
    logic          ovf_q, irq_en_q, tx_q, tx_d, tick, full, empty, push, pop;
    logic          wr_tx, wr_st, wr_bd, par_cfg, unused_bits;
    logic [5:0]    status;
`ifdef UART_TX_PARITY_EN
    logic          par_cfg_q, par_en_q, par_en_d, par_q, par_d;
    assign par_cfg = par_cfg_q;
`else
    assign par_cfg = 1'b0;
`endif
    assign unused_bits = ^{i_addr_m[W-1:5], i_addr_m[2:0], i_wdata_m[W-1:16]};
    assign wr_tx = i_io_en_m & i_clk_en & i_sw_m & (i_addr_m[4:3] == 2'd0);
    assign wr_st = i_io_en_m & i_clk_en & i_sw_m & (i_addr_m[4:3] == 2'd1);
    assign wr_bd = i_io_en_m & i_clk_en & i_sw_m & (i_addr_m[4:3] == 2'd2);
    assign full  = count_q == (AW+1)'(FIFO_DEPTH);
    assign empty = count_q == '0;
    assign pop   = (state_q == IDLE) & ~empty;
    // a pop in the same cycle frees a slot, so a push on a full FIFO is still accepted
    assign push  = wr_tx & (~full | pop);
    assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    assign status = {par_cfg, irq_en_q, ovf_q, state_q != IDLE, empty, full};
    assign o_rdata_m = ~(i_io_en_m & i_lw_m) ? '0 :
                       i_addr_m[4:3] == 2'd1 ? W'(status) :
                       i_addr_m[4:3] == 2'd2 ? W'(baud_q) : '0;
    assign o_irq = empty & irq_en_q;
    assign o_tx  = tx_q;
    assign tick  = cnt_q == div_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        div_d   = div_q;
`ifdef UART_TX_PARITY_EN
        par_en_d = par_en_q;
        par_d    = par_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!empty) begin
                    state_d = START;
                    shift_d = mem_q[rd_ptr_q];
                    div_d   = baud_q;
                    bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                    par_en_d = par_cfg_q;
                    par_d    = ^mem_q[rd_ptr_q];
`endif
                end
            end
            START: if (tick) begin
                state_d = DATA;
                cnt_d   = '0;
            end
            DATA: if (tick) begin
                cnt_d   = '0;
                shift_d = shift_q >> 1;
                bit_d   = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                if (bit_q == 3'd7) state_d = par_en_q ? PARITY : STOP;
`else
                if (bit_q == 3'd7) state_d = STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (tick) begin
                state_d = STOP;
                cnt_d   = '0;
            end
`endif
            STOP: if (tick) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    // line level follows the registered state, so o_tx lags the state by one clock
`ifdef UART_TX_PARITY_EN
    assign tx_d = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : state_q == PARITY ? par_q : 1'b1;
`else
    assign tx_d = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
`endif
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= i_wdata_m[7:0];
    end
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            baud_q   <= DEFAULT_BAUD_DIV;
            div_q    <= DEFAULT_BAUD_DIV;
            cnt_q    <= '0;
            shift_q  <= '0;
            bit_q    <= '0;
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_cfg_q <= 1'b0;
            par_en_q  <= 1'b0;
            par_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_q + AW'(push);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            count_q  <= count_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            ovf_q    <= (ovf_q & ~(wr_st & i_wdata_m[3])) | (wr_tx & full & ~pop);
            if (wr_st) irq_en_q <= i_wdata_m[4];
            if (wr_bd) baud_q <= i_wdata_m[15:0];
`ifdef UART_TX_PARITY_EN
            if (wr_st) par_cfg_q <= i_wdata_m[5];
            par_en_q <= par_en_d;
            par_q    <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx: directed stimulus with a byte scoreboard; a line monitor rebuilds each frame and compares it sample by sample.
module tb_io_uart_tx;
    logic        clk = 1'b0, rst_n = 1'b0, clk_en = 1'b1, io_en = 1'b0, sw = 1'b0, lw = 1'b0;
    logic [63:0] addr = '0, wdata = '0, rdata;
    logic        tx, irq;
    int          checks = 0, failures = 0, frames = 0;
    typedef struct { logic [7:0] d; int n; bit p; } exp_t;
    exp_t        exp_q[$];

    always #5 clk = ~clk;

    io_uart_tx dut (
        .i_clk(clk), .i_rst(rst_n), .i_clk_en(clk_en), .i_io_en_m(io_en), .i_sw_m(sw),
        .i_lw_m(lw), .i_addr_m(addr), .i_wdata_m(wdata), .o_rdata_m(rdata), .o_tx(tx), .o_irq(irq)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [63:0] d);
        @(negedge clk);
        io_en = 1'b1; sw = 1'b1; addr = 64'(a); wdata = d;
        @(posedge clk);
        #1 io_en = 1'b0; sw = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int n, input bit p);
        exp_t e;
        e.d = b; e.n = n; e.p = p;
        exp_q.push_back(e);
        wr(5'h00, 64'(b));
    endtask

    task automatic chk_rd(input string name, input logic [4:0] a, input logic [63:0] req);
        logic [63:0] d;
        io_en = 1'b1; lw = 1'b1; addr = 64'(a);
        #1 d = rdata;
        io_en = 1'b0; lw = 1'b0;
        chk(name, d, req);
    endtask

    task automatic wait_frames(input int n, input int budget);
        for (int t = 0; t < budget && frames < n; t++) @(posedge clk);
        #1 chk("frames_done", 64'(frames), 64'(n));
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input bit p, input int s);
        if (s == 0) return 1'b0;
        if (s <= 8) return d[s-1];
        if (s == 9 && p) return ^d;
        return 1'b1;
    endfunction

    initial begin : monitor
        logic prev;
        exp_t e;
        int   bad, first;
        bit   abort;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && prev && !tx) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_frame: start bit seen with no byte expected");
                end else begin
                    e = exp_q.pop_front();
                    bad = 0; first = -1; abort = 1'b0;
                    for (int i = 0; i < (e.p ? 11 : 10) * e.n; i++) begin
                        if (i > 0) @(negedge clk);
                        if (!rst_n) begin
                            abort = 1'b1;
                            break;
                        end
                        if (tx !== exp_bit(e.d, e.p, i / e.n)) begin
                            if (bad == 0) first = i;
                            bad++;
                        end
                    end
                    if (!abort) begin
                        chk($sformatf("frame_%02h_bad_samples_first_at_%0d", e.d, first), 64'(bad), 64'd0);
                        frames++;
                    end
                end
            end
            prev = rst_n ? tx : 1'b1;
        end
    end

    initial begin
        int f;
        repeat (3) @(posedge clk);
        #1 chk("rst_tx", 64'(tx), 64'd1);
        chk("rst_irq", 64'(irq), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 chk_rd("rst_status", 5'h08, 64'h02);
        chk_rd("rst_baud", 5'h10, 64'd867);
        chk_rd("txdata_reads_zero", 5'h00, 64'h0);
        io_en = 1'b1; lw = 1'b0; addr = 64'h10;
        #1 chk("no_load_no_data", rdata, 64'h0);
        io_en = 1'b0;
        wr(5'h18, 64'hFFFF);
        chk_rd("reserved_reads_zero", 5'h18, 64'h0);
        chk_rd("reserved_write_ignored", 5'h10, 64'd867);

        wr(5'h10, 64'd3);
        chk_rd("baud_written", 5'h10, 64'd3);
        send(8'h55, 4, 1'b0);
        chk_rd("status_after_push", 5'h08, 64'h00);
        @(posedge clk);
        #1 chk_rd("status_start", 5'h08, 64'h06);
        repeat (20) @(posedge clk);
        #1 chk_rd("status_mid_frame", 5'h08, 64'h06);
        wait_frames(1, 100);
        chk_rd("status_after_frame", 5'h08, 64'h02);

        wr(5'h10, 64'd39);
        send(8'h11, 40, 1'b0);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i), 40, 1'b0);
        wr(5'h00, 64'hEE);
        chk_rd("status_overflow", 5'h08, 64'h0D);
        wr(5'h08, 64'h08);
        chk_rd("status_ovf_cleared", 5'h08, 64'h05);
        wait_frames(10, 4500);

        wr(5'h10, 64'd3);
        wr(5'h08, 64'h10);
        chk("irq_empty", 64'(irq), 64'd1);
        send(8'hA3, 4, 1'b0);
        chk("irq_drop_on_push", 64'(irq), 64'd0);
        @(posedge clk);
        #1 chk("irq_rise_on_drain", 64'(irq), 64'd1);
        chk_rd("status_irq_busy", 5'h08, 64'h16);
        wait_frames(11, 100);
        wr(5'h08, 64'h00);
        chk("irq_disabled", 64'(irq), 64'd0);

        send(8'h3C, 4, 1'b0);
        repeat (10) @(posedge clk);
        wr(5'h10, 64'd1);
        chk_rd("baud_mid_frame", 5'h10, 64'd1);
        send(8'hC5, 2, 1'b0);
        wait_frames(13, 200);

        wr(5'h10, 64'd3);
        send(8'hF7, 4, 1'b0);
        send(8'h81, 4, 1'b0);
        for (int t = 0; t < 20 && tx; t++) @(negedge clk);
        chk("rst_test_start_seen", 64'(tx), 64'd0);
        repeat (17) @(negedge clk);
        chk("rst_test_in_bit3", 64'(tx), 64'd0);
        #2 rst_n = 1'b0;
        #1 chk("rst_abort_tx_high", 64'(tx), 64'd1);
        chk_rd("rst_abort_status", 5'h08, 64'h02);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        exp_q.delete();
        f = frames;
        chk_rd("post_rst_status", 5'h08, 64'h02);
        chk_rd("post_rst_baud", 5'h10, 64'd867);
        repeat (40) @(posedge clk);
        #1 chk("no_frame_after_rst", 64'(frames), 64'(f));

        wr(5'h10, 64'd0);
        wr(5'h08, 64'h20);
`ifdef UART_TX_PARITY_EN
        chk_rd("status_parity_en", 5'h08, 64'h22);
        send(8'h07, 1, 1'b1);
        send(8'h80, 1, 1'b1);
`else
        chk_rd("status_bit5_fixed", 5'h08, 64'h02);
        send(8'h07, 1, 1'b0);
        send(8'h80, 1, 1'b0);
`endif
        wait_frames(f + 2, 100);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/io_uart_tx.md
Name: io_uart_tx

Overview:
- Memory-mapped UART transmitter on the SoC IO window (IO_START..IO_END).
- Consumes the memory-stage IO select, store/load strobes, translated offset and store data.
- Sits on the IO leg of the memory stage, alongside the data RAM/ROM.
- Buffers bytes in a FIFO and serialises them 8N1 on o_tx.
- Returns status/config words on the memory-stage read bus.

Parameters:
- XLEN, 2'b10 (`XLEN_64b`), data width = 1<<(XLEN+4) bits.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..64.
- DEFAULT_BAUD_DIV, 16'd867, reset value of the BAUD register; one bit lasts BAUD_DIV+1 clocks.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset; asynchronous, active-low.
- i_clk_en  in  1  pipeline step enable; qualifies bus accesses only.
- i_io_en_m  in  1  IO window selected by the mapper, piped to memory stage.
- i_sw_m  in  1  store strobe, memory stage.
- i_lw_m  in  1  load strobe, memory stage.
- i_addr_m  in  XLEN-width  translated offset inside the IO window; bits [4:3] decode.
- i_wdata_m  in  XLEN-width  store data.
- o_rdata_m  out  XLEN-width  load data; combinational.
- o_tx  out  1  serial line, idle high.
- o_irq  out  1  level interrupt: FIFO empty AND IRQ_EN.

Behaviour:
Register map (byte offsets):
- 0x00 TXDATA (W)
  - Store pushes i_wdata_m[7:0] into the FIFO.
  - Reads as 0.
- 0x08 STATUS (R/W1C)
  - [0] full, [1] empty, [2] busy (FSM not IDLE), [3] overflow (sticky), [4] IRQ_EN (R/W).
  - Store: writing 1 to bit3 clears overflow; bit4 is written directly.
- 0x10 BAUD (R/W), [15:0] divider.
- 0x18 reserved; reads 0, writes ignored.

Bus access:
- An access requires i_io_en_m & i_clk_en.
- Writes commit on posedge i_clk when i_sw_m is also high.
- Loads:
  - o_rdata_m is zero-extended register content when i_io_en_m & i_lw_m, else 0.
  - No load side effects.
  - Zero wait states.

FIFO:
- Circular buffer with rd/wr pointers of log2(FIFO_DEPTH) bits plus a count.
- Pointers wrap modulo FIFO_DEPTH.
- Push while full: byte dropped, overflow set, pointers unchanged.
- Push and pop in the same cycle: both performed, count unchanged.
- A push on a full FIFO coinciding with a pop is accepted, and overflow is not set.

TX FSM:
- Runs on every i_clk and is independent of i_clk_en, so single-stepping does not stretch bits.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - o_tx = 1.
  - If FIFO not empty: pop into the shift register, latch BAUD into the frame divider, clear bit counter and baud counter, go to START.
- START: o_tx = 0 for div+1 clocks, then go to DATA.
- DATA:
  - o_tx = shift[0], LSB first.
  - Each bit lasts div+1 clocks, then shift right.
  - After bit 7 go to STOP (or PARITY, see Optional Feature).
- STOP: o_tx = 1 for div+1 clocks, then go to IDLE.
- Back-to-back bytes have no idle gap beyond the single IDLE cycle.
- BAUD written mid-frame: takes effect from the next frame only.
- BAUD = 0: each bit lasts 1 clock.
- Pop occurs on the IDLE->START transition cycle.
- o_tx is driven from a register, one flop after the state update, and is glitch-free.

Reset (asynchronous, active-low):
- Outputs and state: o_tx=1, o_irq=0, FSM IDLE.
- FIFO: empty, pointers 0.
- STATUS: overflow=0, IRQ_EN=0.
- BAUD = DEFAULT_BAUD_DIV.
- Reset asserted mid-frame aborts the frame immediately: o_tx returns high in the same cycle and buffered bytes are lost.

Optional Feature:
Macro UART_TX_PARITY_EN.
- When defined:
  - STATUS[5] is a parity-enable bit (R/W, reset 0).
  - With STATUS[5]=1, a PARITY state sits between DATA and STOP.
  - PARITY drives the even-parity bit (XOR of the 8 data bits) for div+1 clocks; the frame becomes 8E1.
  - The enable is latched per frame, like BAUD.
- When undefined:
  - STATUS[5] reads 0 and is not writable.
  - No PARITY state is built; frame is fixed 8N1.

Test Plan:
- Reset, BAUD=3, store 0x55 to 0x00 -> o_tx:
  - 0 for 4 clks;
  - bits 1,0,1,0,1,0,1,0 at 4 clks each;
  - 1 for 4 clks;
  - 40 clks total; busy high throughout; empty=1 by second clock of START.
- Push 9 bytes back-to-back with FIFO_DEPTH=8 while the FSM is stalled behind a long BAUD -> ninth byte dropped, STATUS[3]=1.
  - Write 0x08 to STATUS -> overflow clears.
  - All 8 accepted bytes then transmit in order.
- Set IRQ_EN (store 0x10 to STATUS), push 0xA3 -> o_irq drops on push, rises when FIFO drains, while busy is still 1.
- Write BAUD=1 mid-frame of a BAUD=3 byte -> current frame keeps 4 clk/bit; next byte uses 2 clk/bit.
- Assert i_rst low during DATA bit 3 -> o_tx=1 and FIFO empty immediately; after release STATUS reads 0x02 and BAUD reads DEFAULT_BAUD_DIV.
- With UART_TX_PARITY_EN, STATUS[5]=1, byte 0x07, BAUD=0 -> frame 0,1,1,1,0,0,0,0,0,1(parity),1 over 11 clks.
